dm_lsu: RTL and testbench

Load/store unit that acts as the initiator on the word-wide data-memory port of the 32-bit MIPS CPU. It accepts one load or store request at a time from the MEM stage and drives the 14-bit byte-addressed, little-endian memory port. Sub-word loads are returned sign- or zero-extended. Sub-word stores are performed as a two-cycle read-modify-write, because the memory only supports full-word writes.

---
 rtl/dm_lsu_pkg.sv | 39 +++
 rtl/dm_lsu_if.sv | 31 +++
 rtl/dm_lsu_lane.sv | 57 +++++
 rtl/dm_lsu.sv | 117 +++++++++++
 tb/tb_dm_lsu.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared types for the data-memory load/store unit: op codes, FSM states, small helpers.
package dm_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  function automatic logic is_store(input lsu_op_e op);
    return (op >= OP_SW);
  endfunction

  // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response handshake plus word-wide data-memory port of the load/store unit.
interface dm_lsu_if
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  lsu_op_e           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  // The LSU side; memory read data arrives as an input alongside the request.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dm_lsu_lane.sv
// Combinational lane logic: little-endian load extraction/extension and sub-word store merge.
module dm_lsu_lane
  import dm_lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] mrg_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      2'd3: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    ld_data = rd_word;
    case (op)
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'h0000, half_sel};
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'h000000, byte_sel};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    st_data = mrg_word;
    case (op)
      OP_SW: st_data = wdata;
      OP_SH: begin
        if (lane[1]) st_data[31:16] = wdata[15:0];
        else         st_data[15:0]  = wdata[15:0];
      end
      OP_SB: begin
        case (lane)
          2'd0: st_data[7:0]   = wdata[7:0];
          2'd1: st_data[15:8]  = wdata[7:0];
          2'd2: st_data[23:16] = wdata[7:0];
          2'd3: st_data[31:24] = wdata[7:0];
          default: st_data = mrg_word;
        endcase
      end
      default: st_data = mrg_word;
    endcase
  end
endmodule

// File: rtl/dm_lsu.sv
// Data-memory load/store unit: one request at a time, sub-word stores via read-modify-write.
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int ADDR_W = 14
)(
  input  logic      clk,
  input  logic      rst_n,
  dm_lsu_if.slave   bus
);
  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              misalign;
  logic              req_ready;
  logic              resp_valid;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = is_misaligned(bus.req_op, bus.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.req_valid;

  dm_lsu_lane u_lane (
    .op       (op_q),
    .lane     (addr_q[1:0]),
    .rd_word  (bus.mem_rdata),
    .mrg_word (merge_q),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  // Write strobe and data are pure state decodes, so an async reset kills a pending write.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (misalign)                                          state_d = RESP;
          else if (bus.req_op == OP_SH || bus.req_op == OP_SB)   state_d = RMW_RD;
          else                                                   state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (is_store(op_q)) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
        state_d = RESP;
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = st_data;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        rdata_q <= '0;
        err_q   <= misalign;
      end else if (state_q == ACCESS && !is_store(op_q)) begin
        rdata_q <= ld_data;
      end
    end
  end

  // Pure data registers: only observed in states entered after they are loaded.
  always_ff @(posedge clk) begin
    if (accept)              wdata_q <= bus.req_wdata;
    if (state_q == RMW_RD)   merge_q <= bus.mem_rdata;
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata  = mem_wdata;
  assign bus.mem_we     = mem_we;
endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a word-array memory model; honours LSU_ALIGN_CHECK_EN.
module tb_dm_lsu;
  import dm_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  dm_lsu_if #(.ADDR_W(14)) bus ();

  dm_lsu #(.ADDR_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095] = '{default: 32'h0};
  assign bus.mem_rdata = mem[bus.mem_addr[13:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[13:2]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, check latency, data and write pattern.
  task automatic run_req(input string tag, input lsu_op_e op, input logic [13:0] addr,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input logic err, input int nwe, input int fwe);
    int cyc;
    int wes;
    int first;
    bit got;
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 1; wes = 0; first = -1; got = 1'b0;
    while (cyc <= 8) begin
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.mem_we) begin
        wes++;
        if (first < 0) first = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_rdata"}, bus.resp_rdata, rd);
    chk({tag, "_err"}, {31'b0, bus.resp_err}, {31'b0, err});
    chk({tag, "_we_cnt"}, wes, nwe);
    chk({tag, "_we_first"}, first, fwe);
    if (bus.resp_ready) begin
      @(posedge clk); #1;
      chk({tag, "_idle_ready"}, {30'b0, bus.req_ready, bus.resp_valid}, 32'b10);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_LW;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    #12;
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_rdata",      bus.resp_rdata,          32'd0);
    chk("rst_err",        {31'b0, bus.resp_err},   32'd0);
    chk("rst_mem_we",     {31'b0, bus.mem_we},     32'd0);
    chk("rst_mem_addr",   {18'b0, bus.mem_addr},   32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,           32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("sw10", OP_SW, 14'h0010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 1);
    chk("sw10_mem", mem[4], 32'hDEADBEEF);
    run_req("lw10", OP_LW, 14'h0010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, -1);
    run_req("sb11", OP_SB, 14'h0011, 32'h000000AA, 3, 32'h0, 1'b0, 1, 2);
    chk("sb11_mem", mem[4], 32'hDEADAAEF);
    run_req("sw_restore", OP_SW, 14'h0010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 1);

    run_req("lb13",  OP_LB,  14'h0013, 32'h0, 2, 32'hFFFFFFDE, 1'b0, 0, -1);
    run_req("lbu13", OP_LBU, 14'h0013, 32'h0, 2, 32'h000000DE, 1'b0, 0, -1);
    run_req("lh12",  OP_LH,  14'h0012, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 0, -1);
    run_req("lhu10", OP_LHU, 14'h0010, 32'h0, 2, 32'h0000BEEF, 1'b0, 0, -1);
    run_req("lb11",  OP_LB,  14'h0011, 32'h0, 2, 32'hFFFFFFBE, 1'b0, 0, -1);

`ifdef LSU_ALIGN_CHECK_EN
    run_req("lw12_mis", OP_LW, 14'h0012, 32'h0, 1, 32'h0, 1'b1, 0, -1);
    run_req("sh11_mis", OP_SH, 14'h0011, 32'h00005555, 1, 32'h0, 1'b1, 0, -1);
    chk("sh11_mis_mem", mem[4], 32'hDEADBEEF);
`else
    run_req("lw12_word", OP_LW, 14'h0012, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, -1);
`endif

    // Response backpressure with a competing request that must be ignored.
    bus.resp_ready = 1'b0;
    run_req("bp_lhu12", OP_LHU, 14'h0012, 32'h0, 2, 32'h0000DEAD, 1'b0, 0, -1);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SW;
    bus.req_addr  = 14'h0020;
    bus.req_wdata = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("bp_rdata",      bus.resp_rdata,          32'h0000DEAD);
      chk("bp_err",        {31'b0, bus.resp_err},   32'd0);
      chk("bp_req_ready",  {31'b0, bus.req_ready},  32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'b0, bus.req_ready, bus.resp_valid}, 32'b10);
    chk("bp_ignored_mem", mem[8], 32'h0);

    // Reset while the SH read phase is in progress.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SH;
    bus.req_addr  = 14'h0010;
    bus.req_wdata = 32'h00001234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rmw_rd_we", {31'b0, bus.mem_we}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", {31'b0, bus.mem_we}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_hold_we", {31'b0, bus.mem_we}, 32'd0);
    end
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("mid_rdata",      bus.resp_rdata,          32'd0);
    chk("mid_err",        {31'b0, bus.resp_err},   32'd0);
    chk("mid_mem_addr",   {18'b0, bus.mem_addr},   32'd0);
    chk("mid_mem_wdata",  bus.mem_wdata,           32'd0);
    @(posedge clk); #1;
    chk("mid_after_we",   {31'b0, bus.mem_we},     32'd0);
    chk("mid_mem_word",   mem[4],                  32'hDEADBEEF);
    chk("mid_idle_ready", {31'b0, bus.req_ready},  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
